// File: rtl/max1452_pkg.sv
// Shared types and constants for the MAX1452 configuration sequencer.
// The opcodes name the command bytes that appear in the ROM stream.
package max1452_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SEND,
    ST_GAP,
    ST_FINISH
  } seq_state_e;

  localparam logic [7:0] OP_WRITE_CFG = 8'h01;
  localparam logic [7:0] OP_COMMIT_A  = 8'h06;
  localparam logic [7:0] OP_COMMIT_B  = 8'h09;
  localparam logic [7:0] OP_END       = 8'hFA;

  localparam int DEF_NUM_BYTES = 26;
  localparam int GAP_W         = 16;

  function automatic logic is_commit(input logic [7:0] b);
    return (b == OP_COMMIT_A) || (b == OP_COMMIT_B);
  endfunction

endpackage

// File: rtl/max1452_cfg_seq_if.sv
// ROM read port and TX byte handshake between the sequencer and its neighbours.
interface max1452_cfg_seq_if #(
  parameter int ADDR_W = 5
) ();
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output rom_addr, tx_data, tx_valid, input rom_data, tx_ready);
  modport slave  (input rom_addr, tx_data, tx_valid, output rom_data, tx_ready);
endinterface

// File: rtl/max1452_gap_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module max1452_gap_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/max1452_cfg_seq.sv
// Walks the config ROM and hands each byte to UART TX with valid/ready,
// inserting GAP_CYCLES idle cycles after every accepted byte.
module max1452_cfg_seq
  import max1452_pkg::*;
#(
  parameter int NUM_BYTES  = DEF_NUM_BYTES,
  parameter int ADDR_W     = 5,
  parameter int GAP_CYCLES = 16,
  parameter int LOCK_AFTER = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  max1452_cfg_seq_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W:0]   byte_cnt,
  output logic              unlock
);
  localparam logic [ADDR_W:0]  LAST_CNT = (ADDR_W+1)'(NUM_BYTES);
  localparam bit               HAS_GAP  = (GAP_CYCLES > 0);
  // GAP is left when the counter reads zero, so load one less than the gap
  localparam logic [GAP_W-1:0] GAP_LOAD = HAS_GAP ? GAP_W'(GAP_CYCLES - 1) : '0;

  seq_state_e        state;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic [ADDR_W:0]   cnt_inc;
  logic              accept, gap_zero, advance, last_byte;

  assign bus.rom_addr = rom_addr_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;

  // abort beats a simultaneous handshake: the byte is not counted
  assign accept    = (state == ST_SEND) && tx_valid_q && bus.tx_ready && !abort;
  assign cnt_inc   = (byte_cnt == LAST_CNT) ? byte_cnt : byte_cnt + 1'b1;
  assign advance   = (accept && !HAS_GAP) || (state == ST_GAP && gap_zero);
  assign last_byte = (HAS_GAP ? byte_cnt : cnt_inc) == LAST_CNT;

  max1452_gap_timer #(.W(GAP_W)) u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (accept && HAS_GAP),
    .load_val (GAP_LOAD),
    .dec      (state == ST_GAP),
    .zero     (gap_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rom_addr_q <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      byte_cnt   <= '0;
      unlock     <= 1'b1;
    end else if (state == ST_IDLE || state == ST_FINISH) begin
      if (start) begin
        rom_addr_q <= '0;
        byte_cnt   <= '0;
        done       <= 1'b0;
        aborted    <= 1'b0;
        unlock     <= 1'b1;
        busy       <= 1'b1;
        state      <= ST_FETCH;
      end
    end else if (abort) begin
      tx_valid_q <= 1'b0;
      busy       <= 1'b0;
      aborted    <= 1'b1;
      state      <= ST_IDLE;
    end else begin
      case (state)
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          tx_data_q  <= bus.rom_data;
          tx_valid_q <= 1'b1;
          state      <= ST_SEND;
        end
        ST_SEND: begin
          if (accept) begin
            tx_valid_q <= 1'b0;
            byte_cnt   <= cnt_inc;
            if (HAS_GAP) state <= ST_GAP;
          end
        end
        default: ;
      endcase
      if (advance) begin
        if (last_byte) begin
          state <= ST_FINISH;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (LOCK_AFTER != 0) unlock <= 1'b0;
        end else begin
          rom_addr_q <= rom_addr_q + 1'b1;
          state      <= ST_FETCH;
        end
      end
    end
  end
endmodule

// File: tb/tb_max1452_cfg_seq.sv
// Two sequencers (gapped/unlocked and gapless/locking) against a cycle-schedule
// model plus directed checks on the sent byte stream.
module tb_max1452_cfg_seq;
  localparam int N  = 26;
  localparam int AW = 5;
  localparam logic [7:0] ROM_TAB [N] = '{
    8'h01, 8'hF0, 8'h12, 8'h34, 8'h56, 8'h06, 8'h01, 8'hE1, 8'h00, 8'h80,
    8'h09, 8'h01, 8'hC4, 8'h7F, 8'h20, 8'h00, 8'h06, 8'h01, 8'h3A, 8'h55,
    8'hAA, 8'h09, 8'h01, 8'h10, 8'h06, 8'hFA};
  localparam int GAP_OF  [2] = '{4, 0};
  localparam bit LOCK_OF [2] = '{1'b0, 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst [2], start [2], abort [2], tx_ready [2];
  logic          busy [2], done [2], aborted [2], unlock [2], tx_valid [2];
  logic [AW:0]   byte_cnt [2];
  logic [7:0]    tx_data [2];
  logic [AW-1:0] rom_addr [2];

  max1452_cfg_seq_if #(.ADDR_W(AW)) bus0 ();
  max1452_cfg_seq_if #(.ADDR_W(AW)) bus1 ();

  max1452_cfg_seq #(.NUM_BYTES(N), .ADDR_W(AW), .GAP_CYCLES(4), .LOCK_AFTER(0)) dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .abort(abort[0]), .bus(bus0),
    .busy(busy[0]), .done(done[0]), .aborted(aborted[0]), .byte_cnt(byte_cnt[0]),
    .unlock(unlock[0]));
  max1452_cfg_seq #(.NUM_BYTES(N), .ADDR_W(AW), .GAP_CYCLES(0), .LOCK_AFTER(1)) dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .abort(abort[1]), .bus(bus1),
    .busy(busy[1]), .done(done[1]), .aborted(aborted[1]), .byte_cnt(byte_cnt[1]),
    .unlock(unlock[1]));

  assign bus0.tx_ready = tx_ready[0];
  assign bus1.tx_ready = tx_ready[1];
  assign tx_valid[0] = bus0.tx_valid;
  assign tx_valid[1] = bus1.tx_valid;
  assign tx_data[0]  = bus0.tx_data;
  assign tx_data[1]  = bus1.tx_data;
  assign rom_addr[0] = bus0.rom_addr;
  assign rom_addr[1] = bus1.rom_addr;

  function automatic logic [7:0] rom_rd(input logic [AW-1:0] a);
    return (int'(a) < N) ? ROM_TAB[int'(a)] : 8'hFF;
  endfunction

  always @(posedge clk) begin
    bus0.rom_data <= rom_rd(bus0.rom_addr);
    bus1.rom_data <= rom_rd(bus1.rom_addr);
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, d, cyc, act, exp);
    end
  endtask

  typedef struct { int d; int cyc; logic [7:0] data; int cnt; } hs_t;
  hs_t hs_q[$];

  // Model: outputs derived from event times (start, acceptance) rather than states
  bit m_busy [2]    = '{0, 0};
  bit m_done [2]    = '{0, 0};
  bit m_aborted [2] = '{0, 0};
  bit m_unlock [2]  = '{1, 1};
  int m_cnt [2]       = '{0, 0};
  int m_addr [2]      = '{0, 0};
  int m_valid_at [2]  = '{-1, -1};
  int m_finish_at [2] = '{-1, -1};
  int m_addr_at [2]   = '{-1, -1};
  bit exp_v;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int d = 0; d < 2; d++) begin
        if (m_finish_at[d] == cyc) begin
          m_busy[d] = 0; m_done[d] = 1; m_unlock[d] = !LOCK_OF[d]; m_finish_at[d] = -1;
        end
        if (m_addr_at[d] == cyc) begin
          m_addr[d] = m_addr[d] + 1; m_addr_at[d] = -1;
        end
        exp_v = (m_valid_at[d] >= 0) && (cyc >= m_valid_at[d]);
        chk("busy", d, busy[d], m_busy[d]);
        chk("done", d, done[d], m_done[d]);
        chk("aborted", d, aborted[d], m_aborted[d]);
        chk("unlock", d, unlock[d], m_unlock[d]);
        chk("byte_cnt", d, byte_cnt[d], m_cnt[d]);
        chk("tx_valid", d, tx_valid[d], exp_v);
        if (exp_v) chk("tx_data", d, tx_data[d], ROM_TAB[m_addr[d]]);
        if (exp_v || !m_busy[d]) chk("rom_addr", d, rom_addr[d], m_addr[d]);
        if (tx_valid[d] === 1'b1 && tx_ready[d] === 1'b1 && !rst[d])
          hs_q.push_back('{d, cyc, tx_data[d], int'(byte_cnt[d])});
        if (rst[d]) begin
          m_busy[d] = 0; m_done[d] = 0; m_aborted[d] = 0; m_unlock[d] = 1;
          m_cnt[d] = 0; m_addr[d] = 0;
          m_valid_at[d] = -1; m_finish_at[d] = -1; m_addr_at[d] = -1;
        end else if (!m_busy[d]) begin
          if (start[d]) begin
            m_busy[d] = 1; m_done[d] = 0; m_aborted[d] = 0; m_unlock[d] = 1;
            m_cnt[d] = 0; m_addr[d] = 0; m_valid_at[d] = cyc + 3;
          end
        end else if (abort[d]) begin
          m_busy[d] = 0; m_aborted[d] = 1;
          m_valid_at[d] = -1; m_finish_at[d] = -1; m_addr_at[d] = -1;
        end else if (exp_v && tx_ready[d]) begin
          m_cnt[d] = m_cnt[d] + 1;
          m_valid_at[d] = -1;
          if (m_cnt[d] == N) m_finish_at[d] = cyc + GAP_OF[d] + 1;
          else begin
            m_valid_at[d] = cyc + GAP_OF[d] + 3;
            m_addr_at[d]  = cyc + GAP_OF[d] + 1;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int d);
    start[d] = 1'b1; tick(1); start[d] = 1'b0;
  endtask

  task automatic wait_cnt(input int d, input int target, input int budget);
    int i = 0;
    while (int'(byte_cnt[d]) != target && i < budget) begin tick(1); i++; end
    chk("wait_cnt", d, byte_cnt[d], target);
  endtask

  task automatic wait_valid(input int d, input int budget);
    int i = 0;
    while (tx_valid[d] !== 1'b1 && i < budget) begin tick(1); i++; end
    chk("wait_valid", d, tx_valid[d], 1);
  endtask

  task automatic wait_done(input int d, input int budget);
    int i = 0;
    while (done[d] !== 1'b1 && i < budget) begin tick(1); i++; end
    chk("wait_done", d, done[d], 1);
  endtask

  function automatic int count_from(input int d, input int s);
    int n = 0;
    foreach (hs_q[i]) if (hs_q[i].d == d && hs_q[i].cyc >= s) n++;
    return n;
  endfunction

  task automatic check_run(input int d, input int s, input int sp);
    int n = 0, prev = 0, bad = 0;
    logic [7:0] seen [$];
    foreach (hs_q[i]) begin
      if (hs_q[i].d == d && hs_q[i].cyc >= s) begin
        if (n == 0) chk("first_latency", d, hs_q[i].cyc - s, 3);
        else if (hs_q[i].cyc - prev != sp) bad++;
        prev = hs_q[i].cyc;
        seen.push_back(hs_q[i].data);
        n++;
      end
    end
    chk("hs_count", d, n, N);
    chk("spacing_bad", d, bad, 0);
    if (seen.size() == N) begin
      chk("byte0", d, seen[0], 8'h01);
      chk("byte5", d, seen[5], 8'h06);
      chk("byte25", d, seen[N-1], 8'hFA);
      for (int i = 0; i < N; i++) chk("stream", d, seen[i], ROM_TAB[i]);
    end
  endtask

  int s, s2, s3, nb, n1;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; start[d] = 1'b0; abort[d] = 1'b0; tx_ready[d] = 1'b1;
    end
    tick(3);
    rst[0] = 1'b0; rst[1] = 1'b0;
    chk("rst_busy", 0, busy[0], 0);
    chk("rst_done", 0, done[0], 0);
    chk("rst_unlock", 0, unlock[0], 1);
    chk("rst_cnt", 0, byte_cnt[0], 0);
    chk("rst_valid", 0, tx_valid[0], 0);
    chk("rst_addr", 0, rom_addr[0], 0);
    chk("rst_data", 0, tx_data[0], 8'h00);

    // full stream, with a start pulse mid-run that must be ignored
    s = cyc;
    pulse_start(0);
    wait_cnt(0, 8, 200);
    pulse_start(0);
    wait_done(0, 400);
    chk("fin_busy", 0, busy[0], 0);
    chk("fin_unlock", 0, unlock[0], 1);
    chk("fin_cnt", 0, byte_cnt[0], N);
    check_run(0, s, 7);

    // backpressure on byte index 5
    tick(2);
    s2 = cyc;
    pulse_start(0);
    wait_cnt(0, 5, 200);
    tx_ready[0] = 1'b0;
    wait_valid(0, 50);
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid", 0, tx_valid[0], 1);
      chk("bp_data", 0, tx_data[0], 8'h06);
      chk("bp_cnt", 0, byte_cnt[0], 5);
      tick(1);
    end
    tx_ready[0] = 1'b1;
    tick(1);
    chk("bp_cnt_after", 0, byte_cnt[0], 6);
    n1 = 0;
    foreach (hs_q[i]) if (hs_q[i].d == 0 && hs_q[i].cyc >= s2 && hs_q[i].cnt == 5) n1++;
    chk("bp_one_accept", 0, n1, 1);

    // abort inside the gap after byte 10
    wait_cnt(0, 10, 200);
    tick(1);
    abort[0] = 1'b1; tick(1); abort[0] = 1'b0;
    chk("ab_busy", 0, busy[0], 0);
    chk("ab_aborted", 0, aborted[0], 1);
    chk("ab_cnt", 0, byte_cnt[0], 10);
    nb = count_from(0, s2);
    tick(30);
    chk("ab_no_more_tx", 0, count_from(0, s2), nb);
    chk("ab_addr_frozen", 0, rom_addr[0], 9);

    // restart resends from address 0
    s3 = cyc;
    pulse_start(0);
    wait_valid(0, 10);
    chk("re_addr", 0, rom_addr[0], 0);
    chk("re_data", 0, tx_data[0], 8'h01);
    chk("re_aborted", 0, aborted[0], 0);
    chk("re_cnt", 0, byte_cnt[0], 0);

    // abort lands on the acceptance of byte 3
    wait_cnt(0, 2, 100);
    tx_ready[0] = 1'b0;
    wait_valid(0, 50);
    tx_ready[0] = 1'b1; abort[0] = 1'b1;
    tick(1);
    abort[0] = 1'b0;
    chk("aa_cnt", 0, byte_cnt[0], 2);
    chk("aa_aborted", 0, aborted[0], 1);
    chk("aa_busy", 0, busy[0], 0);
    chk("aa_sent", 0, count_from(0, s3), 3);
    chk("aa_last_byte", 0, hs_q[hs_q.size()-1].data, 8'h12);

    // reset while byte 12 is waiting in SEND
    tick(2);
    pulse_start(0);
    wait_cnt(0, 11, 300);
    tx_ready[0] = 1'b0;
    wait_valid(0, 50);
    tick(3);
    rst[0] = 1'b1; tick(1); rst[0] = 1'b0;
    chk("mr_busy", 0, busy[0], 0);
    chk("mr_done", 0, done[0], 0);
    chk("mr_aborted", 0, aborted[0], 0);
    chk("mr_cnt", 0, byte_cnt[0], 0);
    chk("mr_valid", 0, tx_valid[0], 0);
    chk("mr_data", 0, tx_data[0], 8'h00);
    chk("mr_addr", 0, rom_addr[0], 0);
    chk("mr_unlock", 0, unlock[0], 1);
    tx_ready[0] = 1'b1;
    tick(10);

    // gapless, locking instance
    s = cyc;
    pulse_start(1);
    wait_done(1, 200);
    chk("lk_unlock_low", 1, unlock[1], 0);
    chk("lk_busy", 1, busy[1], 0);
    chk("lk_cnt", 1, byte_cnt[1], N);
    check_run(1, s, 3);
    pulse_start(1);
    chk("lk_unlock_high", 1, unlock[1], 1);
    chk("lk_restart_busy", 1, busy[1], 1);
    chk("lk_restart_done", 1, done[1], 0);
    abort[1] = 1'b1; tick(1); abort[1] = 1'b0;
    chk("lk_aborted", 1, aborted[1], 1);
    // start and abort together while idle: start wins
    start[1] = 1'b1; abort[1] = 1'b1; tick(1);
    start[1] = 1'b0; abort[1] = 1'b0;
    chk("sa_busy", 1, busy[1], 1);
    chk("sa_aborted", 1, aborted[1], 0);
    tick(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
